// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : instr_sequencer
// Purpose  : Plays back stored robot instructions from the instruction FIFO.
//            Pops one entry at a time and drives it to the motor outputs for
//            STEP_CYCLES run cycles, idles the motors for GAP_CYCLES between
//            entries, and reports progress and completion. Supports pause
//            (level) and abort (pulse).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLOCK50     in   1  system clock, rising edge
//   rst_n       in   1  asynchronous active-low reset
//   start       in   1  one-cycle pulse, begins playback from IDLE
//   abort       in   1  one-cycle pulse, cancels playback
//   pause       in   1  level, freezes RUN/GAP while high
//   fifo_empty  in   1  FIFO empty flag
//   fifo_data   in   4  FIFO read data {torque[1:0], dir[1:0]}
//   fifo_re     out  1  FIFO read strobe (one cycle per pop)
//   busy        out  1  high in every state except IDLE
//   cmd_valid   out  1  current command is driving the motors
//   cmd_dir     out  2  current direction (0 when cmd_valid=0)
//   cmd_torque  out  2  current torque (0 when cmd_valid=0)
//   step_count  out  8  entries loaded since last start, saturating
//   done        out  1  one-cycle pulse on normal completion
// ============================================================================
module instr_sequencer #(
  parameter int STEP_CYCLES = 50_000_000,
  parameter int GAP_CYCLES  = 5_000_000
) (
  input  logic       CLOCK50,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       pause,
  input  logic       fifo_empty,
  input  logic [3:0] fifo_data,
  output logic       fifo_re,
  output logic       busy,
  output logic       cmd_valid,
  output logic [1:0] cmd_dir,
  output logic [1:0] cmd_torque,
  output logic [7:0] step_count,
  output logic       done
);

  localparam int MAX_CYC = (STEP_CYCLES > GAP_CYCLES) ? STEP_CYCLES : GAP_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);

  localparam logic [TW-1:0] STEP_LOAD = TW'(STEP_CYCLES - 1);
  // With no gap the GAP state is never entered; the reload value is unused.
  localparam logic [TW-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? TW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    cmd_q, cmd_d;
  logic [7:0]    cnt_q, cnt_d;
  // pause is registered so that cmd_valid depends only on flops. A cycle is
  // "paused" when pause was high during the previous cycle; both the timer
  // freeze and the cmd_valid mask use this same registered view.
  logic          pause_q;

  always_ff @(posedge CLOCK50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      cmd_q   <= '0;
      cnt_q   <= '0;
      pause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      pause_q <= pause;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;

    // abort outranks pause and expiry; step_count is left untouched.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cmd_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cnt_d   = '0;
            state_d = fifo_empty ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: state_d = S_LOAD;
        S_LOAD: begin
          cmd_d   = fifo_data;
          timer_d = STEP_LOAD;
          state_d = S_RUN;
          if (cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_RUN: begin
          if (!pause_q) begin
            if (timer_q == '0) begin
              if (fifo_empty) begin
                state_d = S_DONE;
              end else if (GAP_CYCLES == 0) begin
                state_d = S_FETCH;
              end else begin
                state_d = S_GAP;
                timer_d = GAP_LOAD;
              end
            end else begin
              timer_d = timer_q - TW'(1);
            end
          end
        end
        S_GAP: begin
          if (!pause_q) begin
            if (timer_q == '0) begin
              state_d = fifo_empty ? S_DONE : S_FETCH;
            end else begin
              timer_d = timer_q - TW'(1);
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign fifo_re    = (state_q == S_FETCH);
  assign busy       = (state_q != S_IDLE);
  assign cmd_valid  = (state_q == S_RUN) && !pause_q;
  assign cmd_dir    = cmd_valid ? cmd_q[1:0] : 2'b00;
  assign cmd_torque = cmd_valid ? cmd_q[3:2] : 2'b00;
  assign step_count = cnt_q;
  assign done       = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_sequencer
// Purpose  : Self-checking bench for instr_sequencer. Two instances share the
//            control inputs: one with a 2-cycle gap, one with no gap. Each
//            has its own FIFO model. Expected per-cycle outputs come from a
//            schedule model built from the playback rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

  localparam int S    = 4;
  localparam int GA   = 2;
  localparam int GB   = 0;
  localparam int MAXC = 160;

  logic clk = 1'b0;
  logic rst_n, start, abort, pause;

  logic       re_a, busy_a, val_a, done_a, empty_a;
  logic [1:0] dir_a, tq_a;
  logic [7:0] cnt_a;
  logic [3:0] data_a = 4'h0;
  logic       re_b, busy_b, val_b, done_b, empty_b;
  logic [1:0] dir_b, tq_b;
  logic [7:0] cnt_b;
  logic [3:0] data_b = 4'h0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_sequencer #(.STEP_CYCLES(S), .GAP_CYCLES(GA)) dut_a (
    .CLOCK50(clk), .rst_n(rst_n), .start(start), .abort(abort), .pause(pause),
    .fifo_empty(empty_a), .fifo_data(data_a), .fifo_re(re_a), .busy(busy_a),
    .cmd_valid(val_a), .cmd_dir(dir_a), .cmd_torque(tq_a),
    .step_count(cnt_a), .done(done_a)
  );

  instr_sequencer #(.STEP_CYCLES(S), .GAP_CYCLES(GB)) dut_b (
    .CLOCK50(clk), .rst_n(rst_n), .start(start), .abort(abort), .pause(pause),
    .fifo_empty(empty_b), .fifo_data(data_b), .fifo_re(re_b), .busy(busy_b),
    .cmd_valid(val_b), .cmd_dir(dir_b), .cmd_torque(tq_b),
    .step_count(cnt_b), .done(done_b)
  );

  // FIFO models: data appears the cycle after the read strobe.
  logic [3:0] mem_a [64];
  logic [3:0] mem_b [64];
  int wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;

  always @(posedge clk) begin
    if (re_a) begin
      data_a <= mem_a[rd_a[5:0]];
      rd_a   <= rd_a + 1;
    end
    if (re_b) begin
      data_b <= mem_b[rd_b[5:0]];
      rd_b   <= rd_b + 1;
    end
  end

  assign empty_a = (wr_a == rd_a);
  assign empty_b = (wr_b == rd_b);

  // Expected outputs per cycle: {re, busy, valid, dir, torque, done, count}
  logic [15:0] exp_v [2][MAXC];
  int          ep_end [2];
  int          last_cnt [2];
  bit          pz [MAXC];
  logic [3:0]  ent [3];
  int          re_at [2][4];
  int          re_n [2];

  function automatic logic [15:0] pk(input logic re, input logic bz, input logic vl,
                                     input logic [1:0] dr, input logic [1:0] tq,
                                     input logic dn, input logic [7:0] cn);
    return {re, bz, vl, dr, tq, dn, cn};
  endfunction

  // Cycle 0 carries the start pulse; a cycle counts as paused when pause was
  // driven during the cycle before it.
  task automatic build(input int d, input int g, input int n, input int ab);
    int c;
    int left;
    int cnt;
    logic [7:0] hold;
    exp_v[d][0] = pk(0, 0, 0, 2'b00, 2'b00, 0, 8'(last_cnt[d]));
    c   = 1;
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      exp_v[d][c] = pk(1, 1, 0, 2'b00, 2'b00, 0, 8'(cnt)); c++;
      exp_v[d][c] = pk(0, 1, 0, 2'b00, 2'b00, 0, 8'(cnt)); c++;
      if (cnt < 255) cnt++;
      left = S;
      while (left > 0) begin
        if (pz[c-1]) exp_v[d][c] = pk(0, 1, 0, 2'b00, 2'b00, 0, 8'(cnt));
        else begin
          exp_v[d][c] = pk(0, 1, 1, ent[k][1:0], ent[k][3:2], 0, 8'(cnt));
          left--;
        end
        c++;
      end
      if (k < n - 1) begin
        left = g;
        while (left > 0) begin
          exp_v[d][c] = pk(0, 1, 0, 2'b00, 2'b00, 0, 8'(cnt));
          if (!pz[c-1]) left--;
          c++;
        end
      end
    end
    exp_v[d][c] = pk(0, 1, 0, 2'b00, 2'b00, 1, 8'(cnt)); c++;
    ep_end[d] = c;
    for (int i = c; i < MAXC; i++) exp_v[d][i] = pk(0, 0, 0, 2'b00, 2'b00, 0, 8'(cnt));
    if (ab >= 1 && ab < c) begin
      hold = exp_v[d][ab][7:0];
      for (int i = ab + 1; i < MAXC; i++) exp_v[d][i] = pk(0, 0, 0, 2'b00, 2'b00, 0, hold);
      ep_end[d] = ab + 1;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic run_ep(input int n, input int ab);
    int len;
    logic [15:0] obs;
    build(0, GA, n, ab);
    build(1, GB, n, ab);
    len = ((ep_end[0] > ep_end[1]) ? ep_end[0] : ep_end[1]) + 3;
    wr_a = rd_a;
    wr_b = rd_b;
    for (int k = 0; k < n; k++) begin
      mem_a[wr_a[5:0]] = ent[k]; wr_a++;
      mem_b[wr_b[5:0]] = ent[k]; wr_b++;
    end
    re_n[0] = 0;
    re_n[1] = 0;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      obs = pk(re_a, busy_a, val_a, dir_a, tq_a, done_a, cnt_a);
      total++;
      assert (obs === exp_v[0][c]) else begin
        bad++;
        $error("FAIL trace_a cyc=%0d observed=%h expected=%h", c, obs, exp_v[0][c]);
      end
      obs = pk(re_b, busy_b, val_b, dir_b, tq_b, done_b, cnt_b);
      total++;
      assert (obs === exp_v[1][c]) else begin
        bad++;
        $error("FAIL trace_b cyc=%0d observed=%h expected=%h", c, obs, exp_v[1][c]);
      end
      if (re_a && re_n[0] < 4) begin re_at[0][re_n[0]] = c; re_n[0]++; end
      if (re_b && re_n[1] < 4) begin re_at[1][re_n[1]] = c; re_n[1]++; end
      start = (c == 0);
      pause = pz[c];
      abort = (c == ab);
    end
    start = 1'b0;
    pause = 1'b0;
    abort = 1'b0;
    last_cnt[0] = int'(exp_v[0][len-1][7:0]);
    last_cnt[1] = int'(exp_v[1][len-1][7:0]);
  endtask

  task automatic clr_pause();
    for (int i = 0; i < MAXC; i++) pz[i] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    pause = 1'b0;
    last_cnt[0] = 0;
    last_cnt[1] = 0;
    clr_pause();

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("reset_a", int'(pk(re_a, busy_a, val_a, dir_a, tq_a, done_a, cnt_a)), 0);
    chk("reset_b", int'(pk(re_b, busy_b, val_b, dir_b, tq_b, done_b, cnt_b)), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Three-entry playback
    ent[0] = 4'h1; ent[1] = 4'h6; ent[2] = 4'hB;
    run_ep(3, -1);
    chk("pop_count_a", re_n[0], 3);
    chk("pop_gap_a_1", re_at[0][1] - re_at[0][0], 8);
    chk("pop_gap_a_2", re_at[0][2] - re_at[0][1], 8);
    chk("pop_gap_b_1", re_at[1][1] - re_at[1][0], 6);
    chk("steps_a", int'(cnt_a), 3);

    // Empty start
    run_ep(0, -1);
    chk("empty_pops_a", re_n[0], 0);
    chk("empty_steps_a", int'(cnt_a), 0);

    // Pause held for 5 cycles starting in the 2nd RUN cycle
    ent[0] = 4'h9; ent[1] = 4'h2;
    for (int i = 4; i <= 8; i++) pz[i] = 1'b1;
    run_ep(2, -1);
    chk("pause_second_pop_a", re_at[0][1], 14);
    clr_pause();

    // Abort in the first GAP cycle with two entries still queued
    ent[0] = 4'h3; ent[1] = 4'hC; ent[2] = 4'h5;
    run_ep(3, 7);
    chk("abort_steps_a", int'(cnt_a), 1);
    chk("abort_left_a", wr_a - rd_a, 2);
    chk("abort_pops_a", re_n[0], 1);

    // Abort together with pause in the last RUN cycle
    ent[0] = 4'hE;
    pz[6] = 1'b1;
    run_ep(1, 6);
    clr_pause();

    // Asynchronous reset mid-RUN
    ent[0] = 4'h5; ent[1] = 4'hA;
    wr_a = rd_a; wr_b = rd_b;
    for (int k = 0; k < 2; k++) begin
      mem_a[wr_a[5:0]] = ent[k]; wr_a++;
      mem_b[wr_b[5:0]] = ent[k]; wr_b++;
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_valid_a", int'(val_a), 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_a", int'(pk(re_a, busy_a, val_a, dir_a, tq_a, done_a, cnt_a)), 0);
    chk("async_reset_b", int'(pk(re_b, busy_b, val_b, dir_b, tq_b, done_b, cnt_b)), 0);
    @(negedge clk);
    rst_n = 1'b1;
    last_cnt[0] = 0;
    last_cnt[1] = 0;

    // Zero gap: two entries back-to-back
    run_ep(2, -1);
    chk("zero_gap_spacing_b", re_at[1][1] - re_at[1][0], 6);

    // Randomized episodes
    for (int e = 0; e < 24; e++) begin
      int n;
      int ab;
      n = int'($urandom_range(0, 3));
      for (int k = 0; k < 3; k++) ent[k] = 4'($urandom_range(0, 15));
      clr_pause();
      for (int i = 0; i < 40; i++) pz[i] = ($urandom_range(0, 3) == 0);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : -1;
      run_ep(n, ab);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
